// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared constants and loader state encoding for the instruction-memory loader
package mips_pkg;

    // Byte address of instruction word 0 (.text base), shared with the fetch side.
    localparam logic [31:0] TEXT_BASE = 32'h0040_0000;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        WRITE = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } loader_state_e;

endpackage

// File: rtl/byte_assembler.sv
// rtl/byte_assembler.sv - packs a byte stream big-endian into words
//
// Ports:
//   clk, reset   posedge clock, synchronous active-high reset
//   clear        drop any partially assembled word
//   take         a byte is transferred this cycle
//   byte_in      the byte being transferred
//   word         assembled word, valid while word_ready is high
//   word_ready   high in the cycle the final byte of a word is taken
module byte_assembler #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             take,
    input  logic [7:0]       byte_in,
    output logic [WIDTH-1:0] word,
    output logic             word_ready
);

    localparam int BYTES = WIDTH / 8;
    localparam int CW    = $clog2(BYTES);

    logic [WIDTH-9:0] shift;
    logic [CW-1:0]    cnt;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            shift <= '0;
            cnt   <= '0;
        end else if (take) begin
            shift <= {shift[WIDTH-17:0], byte_in};
            cnt   <= cnt + CW'(1);
        end
    end

    // The final byte is not stored: the word is presented combinationally so
    // the caller can capture it in the same cycle and the counter wraps to 0.
    assign word_ready = take && (cnt == CW'(BYTES - 1));
    assign word       = {shift, byte_in};

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - loads a byte-stream program image into instruction RAM
//
// Ports:
//   clk, reset       posedge clock, synchronous active-high reset
//   start_i          begin a load (honoured only in IDLE/DONE/ERR)
//   word_count_i     number of words to load, sampled with start_i
//   byte_i           stream byte; byte_valid_i / byte_ready_o handshake
//   Write_Enable_o   one-cycle write strobe qualifying Address_o / WriteData_o
//   Address_o        byte address of the write (BASE_ADDR + 4*word index)
//   WriteData_o      big-endian packed word
//   busy_o           load in progress; cpu_hold_o mirrors it
//   done_o / err_o   sticky completion / oversize-request flags
module imem_loader
    import mips_pkg::*;
#(
    parameter int                    MEMORY_DEPTH = 64,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR    = TEXT_BASE
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] word_count_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_valid_i,
    output logic                  byte_ready_o,
    output logic                  Write_Enable_o,
    output logic [DATA_WIDTH-1:0] Address_o,
    output logic [DATA_WIDTH-1:0] WriteData_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  cpu_hold_o
);

    loader_state_e state, next_state;

    logic [DATA_WIDTH-1:0] word_count_q;
    logic [DATA_WIDTH-1:0] word_idx;
    logic [DATA_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0] asm_word;
    logic                  asm_word_ready;
    logic                  can_start;
    logic                  start_take;
    logic                  byte_take;

    assign can_start  = (state == IDLE) || (state == DONE) || (state == ERR);
    assign start_take = start_i && can_start;
    assign byte_take  = byte_valid_i && (state == FILL);

    // Clearing on start guarantees a new load never inherits bytes from an
    // earlier, interrupted one.
    byte_assembler #(
        .WIDTH (DATA_WIDTH)
    ) u_byte_assembler (
        .clk        (clk),
        .reset      (reset),
        .clear      (start_take),
        .take       (byte_take),
        .byte_in    (byte_i),
        .word       (asm_word),
        .word_ready (asm_word_ready)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    if (word_count_i == '0) begin
                        next_state = DONE;
                    end else if (word_count_i > DATA_WIDTH'(MEMORY_DEPTH)) begin
                        next_state = ERR;
                    end else begin
                        next_state = FILL;
                    end
                end
            end
            FILL: begin
                if (asm_word_ready) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                // word_idx still names the word being written this cycle.
                if (word_idx + DATA_WIDTH'(1) == word_count_q) begin
                    next_state = DONE;
                end else begin
                    next_state = FILL;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            word_count_q <= '0;
            word_idx     <= '0;
            addr_q       <= '0;
            data_q       <= '0;
        end else begin
            if (start_take) begin
                word_count_q <= word_count_i;
                word_idx     <= '0;
            end else if (state == WRITE) begin
                word_idx <= word_idx + DATA_WIDTH'(1);
            end
            // Captured on the final byte so both are stable through WRITE and
            // then simply held until the next word.
            if (asm_word_ready) begin
                addr_q <= BASE_ADDR + (word_idx << 2);
                data_q <= asm_word;
            end
        end
    end

    assign byte_ready_o   = (state == FILL);
    assign Write_Enable_o = (state == WRITE);
    assign Address_o      = addr_q;
    assign WriteData_o    = data_q;
    assign busy_o         = (state == FILL) || (state == WRITE);
    assign done_o         = (state == DONE);
    assign err_o          = (state == ERR);
    assign cpu_hold_o     = busy_o;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - self-checking bench for imem_loader
module tb_imem_loader;

    localparam logic [31:0] BASE = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] word_count_i = '0;
    logic [7:0]  byte_i = '0;
    logic        byte_valid_i = 1'b0;
    logic        byte_ready_o;
    logic        Write_Enable_o;
    logic [31:0] Address_o;
    logic [31:0] WriteData_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        cpu_hold_o;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  src[$];
    logic [63:0] act_q[$];

    imem_loader dut (
        .clk            (clk),
        .reset          (reset),
        .start_i        (start_i),
        .word_count_i   (word_count_i),
        .byte_i         (byte_i),
        .byte_valid_i   (byte_valid_i),
        .byte_ready_o   (byte_ready_o),
        .Write_Enable_o (Write_Enable_o),
        .Address_o      (Address_o),
        .WriteData_o    (WriteData_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o),
        .cpu_hold_o     (cpu_hold_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (Write_Enable_o === 1'b1) act_q.push_back({Address_o, WriteData_o});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_start(input logic [31:0] cnt);
        @(negedge clk);
        byte_valid_i = 1'b0;
        start_i      = 1'b1;
        word_count_i = cnt;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    task automatic fill_src(input int nbytes);
        src.delete();
        for (int i = 0; i < nbytes; i++) src.push_back(8'($urandom));
    endtask

    // Presents src[first..last-1]; mode 0 = always valid, 1 = toggling, 2 = random.
    // After each word's final byte the next cycle must be the write cycle with ready low.
    task automatic feed(input int first, input int last, input int mode);
        int  idx    = first;
        int  cyc    = 0;
        bit  tog    = 1'b1;
        bit  exp_we = 1'b0;
        bit  v;
        while (idx < last && cyc < 8 * (last - first) + 20) begin
            if (exp_we) begin
                n_cmp++;
                if (Write_Enable_o !== 1'b1 || byte_ready_o !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_latency: we=%b ready=%b required we=1 ready=0", Write_Enable_o, byte_ready_o);
                end
                exp_we = 1'b0;
            end
            case (mode)
                0:       v = 1'b1;
                1:       begin v = tog; tog = ~tog; end
                default: v = 1'($urandom_range(0, 1));
            endcase
            byte_valid_i = v;
            byte_i       = v ? src[idx] : 8'($urandom);
            if (v && byte_ready_o === 1'b1) begin
                if (idx % 4 == 3) exp_we = 1'b1;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        byte_valid_i = 1'b0;
        if (exp_we) begin
            n_cmp++;
            if (Write_Enable_o !== 1'b1 || byte_ready_o !== 1'b0) begin
                n_fail++;
                $display("FAIL write_latency_last: we=%b ready=%b required we=1 ready=0", Write_Enable_o, byte_ready_o);
            end
        end
        n_cmp++;
        if (idx != last) begin
            n_fail++;
            $display("FAIL feed_timeout: accepted %0d bytes, required %0d", idx - first, last - first);
        end
    endtask

    task automatic wait_done();
        int c = 0;
        while (done_o !== 1'b1 && c < 20) begin
            @(negedge clk);
            c++;
        end
        n_cmp++;
        if (done_o !== 1'b1) begin
            n_fail++;
            $display("FAIL done_timeout: done=%b required 1", done_o);
        end
        n_cmp++;
        if (busy_o !== 1'b0 || cpu_hold_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_done: busy=%b hold=%b required 0 0", busy_o, cpu_hold_o);
        end
    endtask

    // Word n of the image lands at BASE + 4n holding bytes 4n..4n+3, first byte most significant.
    task automatic check_writes(input int nwords);
        logic [31:0] ea, ed;
        n_cmp++;
        if (act_q.size() != nwords) begin
            n_fail++;
            $display("FAIL write_count: got %0d writes, required %0d", act_q.size(), nwords);
        end
        for (int n = 0; n < nwords && n < act_q.size(); n++) begin
            ea = BASE + 32'(4 * n);
            ed = {src[4*n], src[4*n+1], src[4*n+2], src[4*n+3]};
            n_cmp++;
            if (act_q[n] !== {ea, ed}) begin
                n_fail++;
                $display("FAIL write_%0d: got addr=%h data=%h, required addr=%h data=%h",
                         n, act_q[n][63:32], act_q[n][31:0], ea, ed);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, err_o, Write_Enable_o, byte_ready_o, cpu_hold_o} !== 6'b0 ||
            Address_o !== 32'h0 || WriteData_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: flags=%b addr=%h data=%h, required all 0",
                     {busy_o, done_o, err_o, Write_Enable_o, byte_ready_o, cpu_hold_o}, Address_o, WriteData_o);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (byte_ready_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ready=%b busy=%b required 0 0", byte_ready_o, busy_o);
        end
    endtask

    task automatic test_back_to_back();
        src = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        act_q.delete();
        do_start(32'd2);
        n_cmp++;
        if (busy_o !== 1'b1 || cpu_hold_o !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_during_load: busy=%b hold=%b required 1 1", busy_o, cpu_hold_o);
        end
        feed(0, 8, 0);
        wait_done();
        check_writes(2);
        n_cmp++;
        if (Address_o !== 32'h0040_0004 || WriteData_o !== 32'h9ABC_DEF0) begin
            n_fail++;
            $display("FAIL hold_last_write: addr=%h data=%h required 00400004 9abcdef0", Address_o, WriteData_o);
        end
    endtask

    task automatic test_toggle_valid();
        src = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        act_q.delete();
        do_start(32'd1);
        feed(0, 4, 1);
        wait_done();
        check_writes(1);
    endtask

    task automatic test_overflow_and_zero();
        act_q.delete();
        do_start(32'd65);
        n_cmp++;
        if (err_o !== 1'b1 || done_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL oversize: err=%b done=%b busy=%b required 1 0 0", err_o, done_o, busy_o);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (act_q.size() != 0) begin
            n_fail++;
            $display("FAIL oversize_writes: got %0d writes, required 0", act_q.size());
        end
        do_start(32'd0);
        n_cmp++;
        if (done_o !== 1'b1 || err_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_count: done=%b err=%b busy=%b required 1 0 0", done_o, err_o, busy_o);
        end
        repeat (4) @(negedge clk);
        n_cmp++;
        if (act_q.size() != 0) begin
            n_fail++;
            $display("FAIL zero_count_writes: got %0d writes, required 0", act_q.size());
        end
    endtask

    task automatic test_full_load();
        fill_src(256);
        act_q.delete();
        do_start(32'd64);
        feed(0, 256, 2);
        wait_done();
        check_writes(64);
        n_cmp++;
        if (act_q.size() != 64 || act_q[act_q.size()-1][63:32] !== 32'h0040_00FC) begin
            n_fail++;
            $display("FAIL full_last_addr: writes=%0d, required 64 ending at 004000fc", act_q.size());
        end
    endtask

    task automatic test_reset_mid_load();
        fill_src(8);
        act_q.delete();
        do_start(32'd2);
        feed(0, 6, 0);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({busy_o, done_o, err_o, Write_Enable_o, byte_ready_o, cpu_hold_o} !== 6'b0 ||
            Address_o !== 32'h0 || WriteData_o !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_mid_load: flags=%b addr=%h data=%h, required all 0",
                     {busy_o, done_o, err_o, Write_Enable_o, byte_ready_o, cpu_hold_o}, Address_o, WriteData_o);
        end
        reset = 1'b0;
        n_cmp++;
        if (act_q.size() != 1) begin
            n_fail++;
            $display("FAIL reset_mid_load_writes: got %0d writes, required 1", act_q.size());
        end
        fill_src(4);
        act_q.delete();
        do_start(32'd1);
        feed(0, 4, 0);
        wait_done();
        check_writes(1);
    endtask

    task automatic test_start_during_fill();
        fill_src(12);
        act_q.delete();
        do_start(32'd3);
        feed(0, 6, 0);
        start_i      = 1'b1;
        word_count_i = 32'd1;
        @(negedge clk);
        start_i      = 1'b0;
        n_cmp++;
        if (busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_fill: busy=%b required 1", busy_o);
        end
        feed(6, 12, 0);
        wait_done();
        check_writes(3);
        fill_src(4);
        act_q.delete();
        do_start(32'd1);
        n_cmp++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_clears_done: done=%b busy=%b required 0 1", done_o, busy_o);
        end
        feed(0, 4, 0);
        wait_done();
        check_writes(1);
    endtask

    task automatic test_random();
        int cnt;
        for (int it = 0; it < 4; it++) begin
            cnt = $urandom_range(1, 8);
            fill_src(4 * cnt);
            act_q.delete();
            do_start(32'(cnt));
            feed(0, 4 * cnt, $urandom_range(0, 2));
            wait_done();
            check_writes(cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_toggle_valid();
        test_overflow_and_zero();
        test_full_load();
        test_reset_mid_load();
        test_start_during_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
